// File: rtl/aes128_key_sched_pkg.sv
// Shared definitions for the AES-128 key expansion engine.
// Holds the round count, the word and round-key types, the round-constant
// seed and reduction polynomial, the FSM state type and the forward S-box.
package aes128_key_sched_pkg;

  localparam int NR       = 10;
  localparam int NK_WORDS = 4;

  typedef logic [127:0] rkey_t;
  typedef logic [31:0]  word_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[(255 - int'(b))*8 +: 8];
  endfunction

endpackage

// File: rtl/aes128_key_sched_step.sv
// aes_key_step: one purely combinational AES-128 key-schedule round.
// Ports:
//   prev_key  in  128  previous round key, word 0 in bits [127:96]
//   rc        in  8    round constant for this round
//   next_key  out 128  following round key
module aes_key_step
  import aes128_key_sched_pkg::*;
(
  input  rkey_t      prev_key,
  input  logic [7:0] rc,
  output rkey_t      next_key
);

  word_t w0, w1, w2, w3;
  word_t rot, t;
  word_t n0, n1, n2, n3;

  always_comb begin
    w0 = prev_key[127:96];
    w1 = prev_key[95:64];
    w2 = prev_key[63:32];
    w3 = prev_key[31:0];
    // RotWord then SubWord, round constant lands in the top byte only
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rc, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes128_key_sched.sv
// aes128_key_sched: sequential AES-128 key expansion, one round key per clock,
// all eleven round keys held in a register file with a combinational read port.
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   key_in     in   128  cipher key, word 0 in bits [127:96]
//   key_valid  in   1    start request, sampled only while ready=1
//   ready      out  1    can accept a key (IDLE or DONE)
//   busy       out  1    expansion in progress
//   done       out  1    one-cycle pulse when round key 10 is stored
//   keys_valid out  1    all round keys match the last accepted key
//   rd_idx     in   4    round-key index 0..10
//   rd_key     out  128  rk[rd_idx], zero for indices 11..15
module aes128_key_sched
  import aes128_key_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] rcon;
  rkey_t      rk [NR+1];
  rkey_t      prev_key;
  rkey_t      step_key;

  // Multiply by x in GF(2^8), reducing on overflow of bit 7.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

  // Previous round key selected by cnt; zero outside the EXPAND range.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < NR; i++) begin
      if (cnt == 4'(i + 1)) prev_key = rk[i];
    end
  end

  aes_key_step u_step (
    .prev_key (prev_key),
    .rc       (rcon),
    .next_key (step_key)
  );

  always_comb begin
    rd_key = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rd_idx == 4'(i)) rd_key = rk[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      rcon       <= RCON_INIT;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (key_valid) begin
            rk[0]      <= key_in;
            cnt        <= 4'd1;
            rcon       <= RCON_INIT;
            keys_valid <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          // key_valid is deliberately ignored here: no queueing, no abort
          for (int i = 1; i <= NR; i++) begin
            if (cnt == 4'(i)) rk[i] <= step_key;
          end
          rcon <= xtime(rcon);
          cnt  <= cnt + 4'd1;
          if (cnt == 4'(NR)) begin
            state      <= ST_DONE;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            keys_valid <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_key_sched.sv
// Self-checking bench for aes128_key_sched. The reference derives the S-box
// from GF(2^8) inversion plus the affine map and expands keys word by word.
module tb_aes128_key_sched;

  typedef logic [127:0] ks_t [11];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         ready, busy, done, keys_valid;
  logic [3:0]   rd_idx = 4'd0;
  logic [127:0] rd_key;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [7:0] m_sbox [256];

  // cycle-level expectations
  ks_t  m_keys;
  ks_t  m_target;
  int   m_left = 0;
  logic m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_kv = 1'b0;

  aes128_key_sched dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] xb = 8'(x);
      for (int y = 1; y < 256; y++) begin
        if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      end
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic ks_t expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    ks_t r;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {m_sbox[tmp[31:24]], m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 11; k++) r[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference timeline: accept at edge T, rk[k] written at edge T+k.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) m_keys[i] <= '0;
      m_left  <= 0;
      m_ready <= 1'b1;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_kv    <= 1'b0;
    end else if (m_left == 0) begin
      m_done <= 1'b0;
      if (key_valid) begin
        m_target  <= expand(key_in);
        m_keys[0] <= key_in;
        m_left    <= 10;
        m_ready   <= 1'b0;
        m_busy    <= 1'b1;
        m_kv      <= 1'b0;
      end
    end else begin
      m_keys[11-m_left] <= m_target[11-m_left];
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done  <= 1'b1;
        m_kv    <= 1'b1;
        m_ready <= 1'b1;
        m_busy  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 128'(ready), 128'(m_ready));
      chk("busy", 128'(busy), 128'(m_busy));
      chk("done", 128'(done), 128'(m_done));
      chk("keys_valid", 128'(keys_valid), 128'(m_kv));
      chk("rd_key", rd_key, (rd_idx <= 4'd10) ? m_keys[rd_idx] : 128'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] k);
    key_in = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk(name, 128'(n), 128'd10);
  endtask

  task automatic sweep(input ks_t e, input string name);
    for (int i = 0; i < 11; i++) begin
      rd_idx = 4'(i);
      #1;
      chk(name, rd_key, e[i]);
      tick();
    end
  endtask

  initial begin
    ks_t ref_a, ref_b, zero_ks;
    logic [127:0] ka, kb;
    int b;

    build_sbox();
    for (int i = 0; i < 11; i++) zero_ks[i] = '0;

    // pin the model to published vectors
    ref_a = expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("model_fips_rk1", ref_a[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_fips_rk10", ref_a[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    ref_b = expand(128'h0);
    chk("model_zero_rk1", ref_b[1], 128'h62636363626363636263636362636363);
    chk("model_zero_rk10", ref_b[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    rst = 1'b1;
    tick(); tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    chk("reset_ready", 128'(ready), 128'd1);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_kv", 128'(keys_valid), 128'd0);

    // FIPS-197 key
    accept(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_done("fips_done_latency");
    rd_idx = 4'd1; #1;
    chk("fips_rk1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_idx = 4'd10; #1;
    chk("fips_rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    chk("done_pulse_falls", 128'(done), 128'd0);
    chk("kv_holds", 128'(keys_valid), 128'd1);

    // all-zero key
    accept(128'h0);
    wait_done("zero_done_latency");
    rd_idx = 4'd1; #1;
    chk("zero_rk1", rd_key, 128'h62636363626363636263636362636363);
    rd_idx = 4'd10; #1;
    chk("zero_rk10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // out-of-range indices read zero
    for (int i = 11; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      chk("rd_idx_oob", rd_key, 128'h0);
    end
    tick();

    // key_valid during EXPAND is ignored
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    accept(ka);
    b = 0;
    while (busy === 1'b1 && b < 30) begin
      b++;
      if (b == 3 || b == 7) begin
        key_in = kb;
        key_valid = 1'b1;
      end
      tick();
      key_valid = 1'b0;
    end
    chk("busy_cycles", 128'(b), 128'd10);
    chk("ignored_done", 128'(done), 128'd1);
    sweep(expand(ka), "ignore_sweep");

    // reset in the middle of an expansion
    accept({$urandom, $urandom, $urandom, $urandom});
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    key_valid = 1'b1;
    tick();
    rst = 1'b0;
    key_valid = 1'b0;
    chk("midrst_ready", 128'(ready), 128'd1);
    chk("midrst_kv", 128'(keys_valid), 128'd0);
    sweep(zero_ks, "midrst_zero");
    ka = {$urandom, $urandom, $urandom, $urandom};
    accept(ka);
    wait_done("fresh_done_latency");
    sweep(expand(ka), "fresh_sweep");

    // back-to-back keys
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    accept(ka);
    wait_done("b2b_a_latency");
    accept(kb);
    chk("b2b_kv_drop", 128'(keys_valid), 128'd0);
    chk("b2b_busy", 128'(busy), 128'd1);
    wait_done("b2b_b_latency");
    sweep(expand(kb), "b2b_sweep");

    // random traffic against the timeline model
    for (int c = 0; c < 600; c++) begin
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      key_valid = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 79) == 0);
      rd_idx    = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0;
    key_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      rd_idx = 4'($urandom_range(0, 10));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
